census_window_seq: RTL and testbench
====================================

Name: census_window_seq

Overview:
Raster-scan sequencer for the census line-buffer/delay-line datapath. It accepts a pixel stream qualifier (valid plus start-of-frame) and generates the shift enable for the shift-register delay lines. It tracks pixel column/row, flags when a full WIN x WIN census window is resident, and reports that window's centre coordinates. It sits between the pixel source and the line buffers/census transform, one instance per image stream.

Parameters:
IMG_W, 640, image width in pixels (>= WIN)
IMG_H, 480, image height in rows (>= WIN)
WIN, 5, census window edge length; odd, >= 3
CW, 10, column counter width; 2**CW >= IMG_W
RW, 9, row counter width; 2**RW >= IMG_H

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  pixel present on the datapath this cycle
in_sof  input  1  qualifies in_valid: this pixel is (0,0) of a new frame
shift_en  output  1  combinational shift enable to the delay lines
col  output  CW  column of the last accepted pixel (registered)
row  output  RW  row of the last accepted pixel (registered)
eol  output  1  pulse: last accepted pixel had col == IMG_W-1
eof  output  1  pulse: last accepted pixel was (IMG_W-1, IMG_H-1)
win_valid  output  1  pulse: full window resident after last accepted pixel
win_col  output  CW  window centre column, valid with win_valid
win_row  output  RW  window centre row, valid with win_valid
frame_done  output  1  pulse: frame completed normally (same cycle as eof)
sof_err  output  1  pulse: in_sof seen mid-frame; frame restarted

Behaviour:
- Reset: state IDLE; all registered outputs 0, including col, row, win_col and win_row. Assertion mid-frame clears immediately. After reset, a new in_sof is required.
- FSM states: IDLE, ACTIVE.
- Accept = in_valid && (in_sof || state == ACTIVE). shift_en = accept && !rst. This is combinational and the only unregistered output.
- IDLE behaviour:
  - in_valid without in_sof is ignored: shift_en=0, no state change.
  - in_valid && in_sof: accept the pixel as (0,0); go to ACTIVE.
- ACTIVE, accepted pixel without in_sof: advance position.
  - col+1, wrapping to 0 at IMG_W-1 with row+1.
  - If this pixel is (IMG_W-1, IMG_H-1): eof=1, eol=1, frame_done=1 next cycle; state goes to IDLE.
- ACTIVE, accepted pixel with in_sof:
  - sof_err=1 next cycle.
  - The pixel is taken as (0,0) of a new frame; stay in ACTIVE.
  - The aborted frame produces no frame_done or eof.
- No accept (gap): counters hold; all pulse outputs are 0 the following cycle.
- Output latency: registered outputs describe the pixel accepted in the previous cycle (1-cycle latency). Pulses last exactly one cycle per accepted pixel.
- Window validity:
  - win_valid=1 for an accepted pixel at (c,r) when c >= WIN-1 and r >= WIN-1.
  - win_col = c - (WIN-1)/2 and win_row = r - (WIN-1)/2; no underflow is possible under that condition.
  - win_col and win_row hold their last value when win_valid=0.
- Windows per frame: (IMG_W-WIN+1)*(IMG_H-WIN+1).
- Arithmetic: all counters are unsigned and wrap only via explicit compare to IMG_W-1 or IMG_H-1. No modulo-2**CW wrap is allowed.

Decomposition:
- Shared package census_pkg holds:
  - the state typedef (IDLE, ACTIVE);
  - the localparam HALF = (WIN-1)/2;
  - the clog2-based width helpers.
- One sub-module, wrap_counter (parameters MAX and WIDTH):
  - inputs: en, clr (load 0);
  - outputs: count, at_max.
- It is instantiated for the column and the row; the row is enabled by col at_max && accept.

Test Plan:
(All with IMG_W=8, IMG_H=4, WIN=3.)
1. Reset with in_valid=1 and in_sof=1 held: shift_en=0, all outputs 0; release reset -> the first accepted pixel gives col=0, row=0 next cycle.
2. 32 back-to-back pixels, sof on the first:
   - eol on pixels 8/16/24/32;
   - first win_valid after pixel 19 (c=2, r=2) with win_col=1, win_row=1;
   - 12 win_valid pulses total;
   - eof=frame_done=1 once, then IDLE.
3. Same frame with in_valid toggled every other cycle: shift_en=0 on gaps, counters hold, pulses only after accepts, still 12 win_valid and 1 frame_done.
4. In IDLE, 5 cycles of in_valid=1 with in_sof=0: shift_en=0 throughout, col=row=0, no pulses.
5. in_sof with pixel 11 mid-frame: sof_err=1 one cycle, col=0 and row=0 next cycle, no frame_done for the aborted frame; a full 32-pixel restart completes normally.
6. Assert rst during pixel 20: outputs 0 in the same cycle (async). Subsequent pixels without in_sof are ignored until an in_sof arrives.

Source files
------------

// File: rtl/census_window_seq_pkg.sv
// -----------------------------------------------------------------------------
// census_pkg
// Shared definitions for the census window raster sequencer:
//   - state_e     : sequencer state (IDLE waits for start-of-frame, ACTIVE scans)
//   - win_half()  : offset from the window's trailing pixel back to its centre
//   - width_for() : bits needed to count 0 .. n-1
// No ports (package).
// -----------------------------------------------------------------------------
package census_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   // HALF for a given window edge; the window geometry is a module parameter,
   // so this is a function rather than a fixed localparam.
   function automatic int win_half(input int win);
      return (win - 1) / 2;
   endfunction

   function automatic int width_for(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/census_window_seq_if.sv
// -----------------------------------------------------------------------------
// census_window_seq_if
// Pixel qualifier in, sequencing/geometry out.
//   master : pixel source side (drives in_valid/in_sof, observes the rest)
//   slave  : sequencer side
// Signals:
//   in_valid, in_sof       pixel present / pixel is (0,0) of a new frame
//   shift_en               combinational delay-line shift enable
//   col, row               position of the last accepted pixel
//   eol, eof, frame_done   end-of-line / end-of-frame pulses
//   win_valid, win_col/row full census window resident and its centre
//   sof_err                start-of-frame seen mid-frame, frame restarted
// -----------------------------------------------------------------------------
interface census_window_seq_if #(
   parameter int CW = 10,
   parameter int RW = 9
);
   logic          in_valid;
   logic          in_sof;
   logic          shift_en;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          eol;
   logic          eof;
   logic          win_valid;
   logic [CW-1:0] win_col;
   logic [RW-1:0] win_row;
   logic          frame_done;
   logic          sof_err;

   modport master (
      output in_valid, in_sof,
      input  shift_en, col, row, eol, eof, win_valid, win_col, win_row,
             frame_done, sof_err
   );

   modport slave (
      input  in_valid, in_sof,
      output shift_en, col, row, eol, eof, win_valid, win_col, win_row,
             frame_done, sof_err
   );
endinterface

// File: rtl/census_window_seq_wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Counts 0..MAX and wraps to 0 by explicit compare against MAX (never by
// power-of-two rollover). clr_i has priority and loads 0.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en_i       advance one step
//   clr_i      load 0
//   count_o    current count
//   at_max_o   count_o == MAX
// -----------------------------------------------------------------------------
module wrap_counter
   import census_pkg::*;
#(
   parameter int MAX   = 7,
   parameter int WIDTH = width_for(MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o,
   output logic             at_max_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign at_max_o = (count_q == WIDTH'(MAX));
   assign count_o  = count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = at_max_o ? '0 : count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/census_window_seq.sv
// -----------------------------------------------------------------------------
// census_window_seq
// Raster-scan sequencer for the census line-buffer/delay-line datapath.
// Accepts a pixel qualifier stream, produces the delay-line shift enable,
// tracks the position of each accepted pixel and flags when a full WIN x WIN
// window is resident, reporting its centre. All outputs except shift_en are
// registered and describe the pixel accepted in the previous cycle.
// Ports:
//   clk     clock (rising edge)
//   rst     asynchronous active-high reset
//   bus_io  census_window_seq_if.slave (pixel qualifier in, geometry out)
// -----------------------------------------------------------------------------
module census_window_seq
   import census_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int WIN   = 5,
   parameter int CW    = 10,
   parameter int RW    = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   census_window_seq_if.slave     bus_io
);

   localparam int HALF = win_half(WIN);

   state_e        state_q;
   logic          eol_q;
   logic          eof_q;
   logic          frame_done_q;
   logic          sof_err_q;
   logic          win_valid_q;
   logic [CW-1:0] win_col_q;
   logic [RW-1:0] win_row_q;

   logic          accept;
   logic          sof;
   logic          col_max;
   logic          row_max;
   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_cnt;

   // Position of the pixel being accepted this cycle
   logic [CW-1:0] pix_col_d;
   logic [RW-1:0] pix_row_d;
   logic          eol_d;
   logic          eof_d;
   logic          win_valid_d;
   logic          sof_err_d;

   assign sof    = bus_io.in_sof;
   assign accept = bus_io.in_valid && (sof || (state_q == ACTIVE));

   assign bus_io.shift_en = accept && !rst;

   // Counters hold the position of the last accepted pixel; a start-of-frame
   // pixel loads (0,0) regardless of where the previous frame stopped.
   wrap_counter #(.MAX(IMG_W - 1), .WIDTH(CW)) u_col_cnt (
      .clk      (clk),
      .rst      (rst),
      .en_i     (accept && !sof),
      .clr_i    (accept && sof),
      .count_o  (col_cnt),
      .at_max_o (col_max)
   );

   wrap_counter #(.MAX(IMG_H - 1), .WIDTH(RW)) u_row_cnt (
      .clk      (clk),
      .rst      (rst),
      .en_i     (accept && !sof && col_max),
      .clr_i    (accept && sof),
      .count_o  (row_cnt),
      .at_max_o (row_max)
   );

   always_comb begin
      pix_col_d = '0;
      pix_row_d = '0;
      if (!sof) begin
         pix_col_d = col_max ? '0 : col_cnt + CW'(1);
         if (col_max) begin
            pix_row_d = row_max ? '0 : row_cnt + RW'(1);
         end else begin
            pix_row_d = row_cnt;
         end
      end
   end

   assign eol_d       = accept && (pix_col_d == CW'(IMG_W - 1));
   assign eof_d       = eol_d && (pix_row_d == RW'(IMG_H - 1));
   assign win_valid_d = accept && (pix_col_d >= CW'(WIN - 1))
                               && (pix_row_d >= RW'(WIN - 1));
   assign sof_err_d   = accept && sof && (state_q == ACTIVE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         eol_q        <= 1'b0;
         eof_q        <= 1'b0;
         frame_done_q <= 1'b0;
         sof_err_q    <= 1'b0;
         win_valid_q  <= 1'b0;
         win_col_q    <= '0;
         win_row_q    <= '0;
      end else begin
         eol_q        <= eol_d;
         eof_q        <= eof_d;
         frame_done_q <= eof_d;
         sof_err_q    <= sof_err_d;
         win_valid_q  <= win_valid_d;
         // Centre is only meaningful with win_valid; otherwise hold
         if (win_valid_d) begin
            win_col_q <= pix_col_d - CW'(HALF);
            win_row_q <= pix_row_d - RW'(HALF);
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= ACTIVE;
               end
            end
            ACTIVE: begin
               // A mid-frame sof restarts the frame and stays ACTIVE
               if (eof_d) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_io.col        = col_cnt;
   assign bus_io.row        = row_cnt;
   assign bus_io.eol        = eol_q;
   assign bus_io.eof        = eof_q;
   assign bus_io.frame_done = frame_done_q;
   assign bus_io.sof_err    = sof_err_q;
   assign bus_io.win_valid  = win_valid_q;
   assign bus_io.win_col    = win_col_q;
   assign bus_io.win_row    = win_row_q;

endmodule

// File: tb/tb_census_window_seq.sv
// -----------------------------------------------------------------------------
// tb_census_window_seq
// Self-checking bench for census_window_seq with an 8x4 image and 3x3 window.
// The reference model tracks the linear index of the last accepted pixel and
// derives column/row/window geometry from it arithmetically.
// -----------------------------------------------------------------------------
module tb_census_window_seq;

   localparam int W    = 8;
   localparam int H    = 4;
   localparam int WN   = 3;
   localparam int CW   = 4;
   localparam int RW   = 3;
   localparam int HALF = (WN - 1) / 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   census_window_seq_if #(.CW(CW), .RW(RW)) bus ();

   census_window_seq #(
      .IMG_W (W),
      .IMG_H (H),
      .WIN   (WN),
      .CW    (CW),
      .RW    (RW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_active;
   int m_p;
   int m_col, m_row, m_wc, m_wr;
   bit m_eol, m_eof, m_win, m_fd, m_serr;

   int win_cnt, fd_cnt, eof_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string ph);
      chk({ph, ".col"},        32'(bus.col),        32'(m_col));
      chk({ph, ".row"},        32'(bus.row),        32'(m_row));
      chk({ph, ".eol"},        32'(bus.eol),        32'(m_eol));
      chk({ph, ".eof"},        32'(bus.eof),        32'(m_eof));
      chk({ph, ".frame_done"}, 32'(bus.frame_done), 32'(m_fd));
      chk({ph, ".sof_err"},    32'(bus.sof_err),    32'(m_serr));
      chk({ph, ".win_valid"},  32'(bus.win_valid),  32'(m_win));
      chk({ph, ".win_col"},    32'(bus.win_col),    32'(m_wc));
      chk({ph, ".win_row"},    32'(bus.win_row),    32'(m_wr));
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_p = 0;
      m_col = 0; m_row = 0; m_wc = 0; m_wr = 0;
      m_eol = 0; m_eof = 0; m_win = 0; m_fd = 0; m_serr = 0;
   endtask

   task automatic model_step(input bit v, input bit s);
      bit acc;
      acc = v && (s || m_active);
      m_eol = 0; m_eof = 0; m_win = 0; m_fd = 0; m_serr = 0;
      if (acc) begin
         if (s) begin
            m_serr = m_active;
            m_p = 0;
            m_active = 1'b1;
         end else begin
            m_p = m_p + 1;
         end
         m_col = m_p % W;
         m_row = m_p / W;
         m_eol = (m_col == W - 1);
         m_eof = (m_p == W * H - 1);
         m_fd  = m_eof;
         if (m_eof) m_active = 1'b0;
         m_win = (m_col >= WN - 1) && (m_row >= WN - 1);
         if (m_win) begin
            m_wc = m_col - HALF;
            m_wr = m_row - HALF;
         end
      end
   endtask

   task automatic step(input bit v, input bit s, input string ph);
      @(negedge clk);
      bus.in_valid = v;
      bus.in_sof   = s;
      #1;
      chk({ph, ".shift_en"}, 32'(bus.shift_en), 32'(v && (s || m_active)));
      @(posedge clk);
      model_step(v, s);
      #1;
      chk_regs(ph);
      if (bus.win_valid === 1'b1)  win_cnt++;
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (bus.eof === 1'b1)        eof_cnt++;
   endtask

   task automatic clear_counts();
      win_cnt = 0; fd_cnt = 0; eof_cnt = 0;
   endtask

   task automatic chk_counts(input string ph, input int wins, input int fds);
      chk({ph, ".win_count"},   32'(win_cnt), 32'(wins));
      chk({ph, ".frame_count"}, 32'(fd_cnt),  32'(fds));
      chk({ph, ".eof_count"},   32'(eof_cnt), 32'(fds));
   endtask

   initial begin
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'b1;
      model_reset();
      clear_counts();

      // 1. Reset held with a start-of-frame pixel presented
      #2 rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("t1.rst.shift_en", 32'(bus.shift_en), 32'(0));
         chk_regs("t1.rst");
      end
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;

      // 4. IDLE ignores pixels without sof
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "t4");

      // 1/2. First accepted pixel then a full back-to-back frame
      clear_counts();
      step(1'b1, 1'b1, "t2");
      for (int i = 1; i < 32; i++) step(1'b1, 1'b0, "t2");
      chk_counts("t2", 12, 1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "t2.idle");

      // 3. Same frame, valid every other cycle
      clear_counts();
      for (int i = 0; i < 64; i++) step((i % 2) == 0, i == 0, "t3");
      chk_counts("t3", 12, 1);

      // 5. Mid-frame sof on pixel 11, then full restart frame
      clear_counts();
      step(1'b1, 1'b1, "t5");
      for (int i = 1; i < 10; i++) step(1'b1, 1'b0, "t5");
      step(1'b1, 1'b1, "t5.sof");
      for (int i = 1; i < 32; i++) step(1'b1, 1'b0, "t5");
      chk_counts("t5", 12, 1);

      // 6. Async reset while pixel 20 is presented
      step(1'b1, 1'b1, "t6");
      for (int i = 1; i < 19; i++) step(1'b1, 1'b0, "t6");
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'b0;
      #1;
      chk("t6.pre.shift_en", 32'(bus.shift_en), 32'(1));
      #1 rst = 1'b1;
      #1;
      model_reset();
      chk("t6.rst.shift_en", 32'(bus.shift_en), 32'(0));
      chk_regs("t6.rst");
      @(posedge clk);
      #1;
      chk_regs("t6.rst2");
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "t6.ign");
      step(1'b1, 1'b1, "t6.sof");

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
